// File: rtl/mbtrain_sb_pkg.sv
// mbtrain_sb_pkg
// Purpose: sideband message codes shared by the MBTRAIN step responders,
//          plus the state encoding of the RX clock-calibration responder.
// Ports:   none (package).
package mbtrain_sb_pkg;

  // Decoded sideband message codes for the RX clock-calibration exchange
  localparam logic [3:0] RXCAL_START_REQ  = 4'b0001;
  localparam logic [3:0] RXCAL_START_RESP = 4'b0010;
  localparam logic [3:0] RXCAL_END_REQ    = 4'b0011;
  localparam logic [3:0] RXCAL_END_RESP   = 4'b0100;
  localparam logic [3:0] SB_MSG_NONE      = 4'b0000;

  // rx_cal_rx state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_CAL        = 3'd2;
  localparam logic [2:0] ST_WAIT_END   = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;
  localparam logic [2:0] ST_ERROR      = 3'd5;

endpackage

// File: rtl/rx_cal_rx_if.sv
// rx_cal_rx_if
// Purpose: sideband-side signal bundle of the RX clock-calibration responder.
// Signals:
//   i_decoded_sideband_message  4  decoded incoming message code
//   i_sideband_valid            1  qualifies the decoded message (one cycle)
//   i_busy_negedge_detected     1  sideband TX finished a transfer
//   i_valid_rx                  1  sideband RX currently presenting a message
//   o_sideband_message          4  outgoing response code
//   o_valid_tx                  1  request to sideband TX to send the response
// Modports: master = sideband block side, slave = responder (rx_cal_rx).
interface rx_cal_rx_if;
  logic [3:0] i_decoded_sideband_message;
  logic       i_sideband_valid;
  logic       i_busy_negedge_detected;
  logic       i_valid_rx;
  logic [3:0] o_sideband_message;
  logic       o_valid_tx;

  modport master (
    output i_decoded_sideband_message, i_sideband_valid,
           i_busy_negedge_detected, i_valid_rx,
    input  o_sideband_message, o_valid_tx
  );

  modport slave (
    input  i_decoded_sideband_message, i_sideband_valid,
           i_busy_negedge_detected, i_valid_rx,
    output o_sideband_message, o_valid_tx
  );
endinterface

// File: rtl/ltsm_timeout_cnt.sv
// ltsm_timeout_cnt
// Purpose: wait-phase timeout counter shared by the MBTRAIN steps.
//   Counts clk cycles while i_run is high; o_expired is asserted on the
//   cycle the count reaches LIMIT-1 (the LIMIT-th running cycle after clear).
// Ports:
//   clk        in  1  clock
//   rst_n      in  1  synchronous active-low reset
//   i_clear    in  1  synchronous clear of the count (wins over i_run)
//   i_run      in  1  count enable
//   o_expired  out 1  timeout strobe (only while i_run)
module ltsm_timeout_cnt #(
  parameter int unsigned LIMIT = 8000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Saturates at LAST so a caller that keeps running never sees a wrap
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = i_run && (r_cnt == LAST);
endmodule

// File: rtl/rx_cal_rx.sv
// rx_cal_rx
// Purpose: partner-side responder for the MBTRAIN receiver-clock calibration
//   step. Answers start-req with start-resp, runs a local calibration window
//   of CAL_CYCLES clocks, answers end-req with end-resp and reports
//   completion or a wait-phase timeout to the MBTRAIN sequencer.
// Ports:
//   clk            in   1  clock
//   rst_n          in   1  synchronous active-low reset
//   i_en           in   1  step enable; low forces IDLE and clears outputs
//   sb             if      sideband bundle (rx_cal_rx_if.slave)
//   o_rx_cal_en    out  1  high during the local calibration window
//   o_test_ack     out  1  step done, held until i_en falls
//   o_timeout_err  out  1  step aborted on timeout, held until i_en falls
module rx_cal_rx
  import mbtrain_sb_pkg::*;
#(
  parameter int unsigned CAL_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  rx_cal_rx_if.slave    sb,
  output logic          o_rx_cal_en,
  output logic          o_test_ack,
  output logic          o_timeout_err
);
  localparam int unsigned CAL_W = $clog2(CAL_CYCLES + 1);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CAL_W-1:0] r_cal_cnt;
  logic             r_pending;
  logic [3:0]       r_msg;
  logic             r_valid_tx;
  logic             r_rx_cal_en;
  logic             r_test_ack;
  logic             r_timeout_err;

  logic w_req_start;
  logic w_req_end;
  logic w_in_wait;
  logic w_expired;
  logic w_tx_clear;

  assign w_req_start = sb.i_sideband_valid &&
                       (sb.i_decoded_sideband_message == RXCAL_START_REQ);
  assign w_req_end   = sb.i_sideband_valid &&
                       (sb.i_decoded_sideband_message == RXCAL_END_REQ);
  assign w_in_wait   = (r_state == ST_WAIT_START) || (r_state == ST_WAIT_END);
  assign w_tx_clear  = sb.i_busy_negedge_detected && !sb.i_valid_rx;

  // Held clear outside the wait states, so each wait phase starts from zero
  ltsm_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (!i_en || !w_in_wait),
    .i_run     (i_en && w_in_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_state       <= ST_IDLE;
      r_cal_cnt     <= '0;
      r_pending     <= 1'b0;
      r_msg         <= '0;
      r_valid_tx    <= 1'b0;
      r_rx_cal_en   <= 1'b0;
      r_test_ack    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Response loads below are later assignments, so a set wins a clear
      if (w_tx_clear) begin
        r_valid_tx <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_state <= ST_WAIT_START;
        end

        ST_WAIT_START: begin
          if (w_req_start) begin
            r_state     <= ST_CAL;
            r_msg       <= RXCAL_START_RESP;
            r_valid_tx  <= 1'b1;
            r_rx_cal_en <= 1'b1;
            r_cal_cnt   <= '0;
          end else if (w_expired) begin
            r_state       <= ST_ERROR;
            r_timeout_err <= 1'b1;
            r_msg         <= SB_MSG_NONE;
          end
        end

        ST_CAL: begin
          // An early end-req is remembered but never shortens the window
          if (w_req_end) begin
            r_pending <= 1'b1;
          end
          if (r_cal_cnt == CAL_LAST) begin
            r_rx_cal_en <= 1'b0;
            r_state     <= ST_WAIT_END;
          end else begin
            r_cal_cnt <= r_cal_cnt + CAL_W'(1);
          end
        end

        ST_WAIT_END: begin
          if (w_req_end || r_pending) begin
            r_pending  <= 1'b0;
            r_state    <= ST_DONE;
            r_msg      <= RXCAL_END_RESP;
            r_valid_tx <= 1'b1;
            r_test_ack <= 1'b1;
          end else if (w_expired) begin
            r_state       <= ST_ERROR;
            r_timeout_err <= 1'b1;
            r_msg         <= SB_MSG_NONE;
          end
        end

        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign sb.o_sideband_message = r_msg;
  assign sb.o_valid_tx         = r_valid_tx;
  assign o_rx_cal_en           = r_rx_cal_en;
  assign o_test_ack            = r_test_ack;
  assign o_timeout_err         = r_timeout_err;
endmodule

// File: tb/tb_rx_cal_rx.sv
// tb_rx_cal_rx
// Purpose: directed self-checking bench for rx_cal_rx with CAL_CYCLES=4 and
//   TIMEOUT_CYCLES=10. Inputs change 1 ns after the rising edge; outputs are
//   checked at the same point, i.e. the values registered by that edge.
module tb_rx_cal_rx;
  import mbtrain_sb_pkg::*;

  logic clk;
  logic rst_n;
  logic i_en;
  logic o_rx_cal_en;
  logic o_test_ack;
  logic o_timeout_err;

  int unsigned n_checks;
  int unsigned n_fail;

  rx_cal_rx_if sb_if ();

  rx_cal_rx #(
    .CAL_CYCLES     (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (i_en),
    .sb            (sb_if),
    .o_rx_cal_en   (o_rx_cal_en),
    .o_test_ack    (o_test_ack),
    .o_timeout_err (o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sideband message for exactly one sampling edge
  task automatic send(input logic [3:0] code);
    sb_if.i_decoded_sideband_message = code;
    sb_if.i_sideband_valid           = 1'b1;
    tick();
    sb_if.i_sideband_valid           = 1'b0;
    sb_if.i_decoded_sideband_message = 4'b0000;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic [3:0] msg, input logic vld,
                           input logic cal, input logic ack, input logic err);
    check_val({tag, ".state"}, 32'(dut.r_state), 32'(st));
    check_val({tag, ".msg"},   32'(sb_if.o_sideband_message), 32'(msg));
    check_val({tag, ".valid"}, 32'(sb_if.o_valid_tx), 32'(vld));
    check_val({tag, ".calen"}, 32'(o_rx_cal_en), 32'(cal));
    check_val({tag, ".ack"},   32'(o_test_ack), 32'(ack));
    check_val({tag, ".err"},   32'(o_timeout_err), 32'(err));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    i_en  = 1'b0;
    sb_if.i_decoded_sideband_message = 4'b0000;
    sb_if.i_sideband_valid           = 1'b0;
    sb_if.i_busy_negedge_detected    = 1'b0;
    sb_if.i_valid_rx                 = 1'b0;
    tick();
    tick();
    check_all("reset", ST_IDLE, 4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_all("idle_en0", ST_IDLE, 4'b0000, 0, 0, 0, 0);

    // ---------------- normal flow + noise + valid handling ----------------
    i_en = 1'b1;
    tick();
    check_all("n.wstart", ST_WAIT_START, 4'b0000, 0, 0, 0, 0);
    send(4'b0011);
    check_all("n.noise3", ST_WAIT_START, 4'b0000, 0, 0, 0, 0);
    send(4'b0100);
    check_all("n.noise4", ST_WAIT_START, 4'b0000, 0, 0, 0, 0);
    send(4'b0111);
    check_all("n.noise7", ST_WAIT_START, 4'b0000, 0, 0, 0, 0);
    send(4'b0001);
    check_all("n.startresp", ST_CAL, 4'b0010, 1, 1, 0, 0);
    // busy negedge while RX is presenting: valid must stay
    sb_if.i_busy_negedge_detected = 1'b1;
    sb_if.i_valid_rx              = 1'b1;
    tick();
    check_all("n.cal1_hold", ST_CAL, 4'b0010, 1, 1, 0, 0);
    sb_if.i_valid_rx = 1'b0;
    tick();
    check_all("n.cal2_clr", ST_CAL, 4'b0010, 0, 1, 0, 0);
    sb_if.i_busy_negedge_detected = 1'b0;
    tick();
    check_all("n.cal3", ST_CAL, 4'b0010, 0, 1, 0, 0);
    tick();
    check_all("n.wend", ST_WAIT_END, 4'b0010, 0, 0, 0, 0);
    send(4'b0001);
    check_all("n.noise1_wend", ST_WAIT_END, 4'b0010, 0, 0, 0, 0);
    // end-req together with a TX clear: the set must win
    sb_if.i_busy_negedge_detected = 1'b1;
    send(4'b0011);
    sb_if.i_busy_negedge_detected = 1'b0;
    check_all("n.endresp_setwin", ST_DONE, 4'b0100, 1, 0, 1, 0);
    sb_if.i_busy_negedge_detected = 1'b1;
    send(4'b0001);
    sb_if.i_busy_negedge_detected = 1'b0;
    check_all("n.done_clr", ST_DONE, 4'b0100, 0, 0, 1, 0);
    send(4'b0011);
    check_all("n.done_ignore", ST_DONE, 4'b0100, 0, 0, 1, 0);
    i_en = 1'b0;
    tick();
    check_all("n.en_drop", ST_IDLE, 4'b0000, 0, 0, 0, 0);

    // ---------------- early end-req during CAL ----------------
    i_en = 1'b1;
    tick();
    send(4'b0001);
    check_all("e.startresp", ST_CAL, 4'b0010, 1, 1, 0, 0);
    tick();
    send(4'b0011);
    check_all("e.pending", ST_CAL, 4'b0010, 1, 1, 0, 0);
    tick();
    check_all("e.cal3", ST_CAL, 4'b0010, 1, 1, 0, 0);
    tick();
    check_all("e.wend", ST_WAIT_END, 4'b0010, 1, 0, 0, 0);
    tick();
    check_all("e.done", ST_DONE, 4'b0100, 1, 0, 1, 0);
    i_en = 1'b0;
    tick();

    // ---------------- timeout in WAIT_START ----------------
    i_en = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_val($sformatf("t.noerr%0d", i), 32'(o_timeout_err), 32'd0);
    end
    tick();
    check_all("t.err", ST_ERROR, 4'b0000, 0, 0, 0, 1);
    send(4'b0001);
    check_all("t.err_hold", ST_ERROR, 4'b0000, 0, 0, 0, 1);
    i_en = 1'b0;
    tick();
    check_all("t.en_drop", ST_IDLE, 4'b0000, 0, 0, 0, 0);

    // request on the expiry cycle wins over the timeout
    i_en = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) tick();
    send(4'b0001);
    check_all("t.req_wins", ST_CAL, 4'b0010, 1, 1, 0, 0);

    // ---------------- abort by i_en, then by reset ----------------
    tick();
    i_en = 1'b0;
    tick();
    check_all("a.en_mid_cal", ST_IDLE, 4'b0000, 0, 0, 0, 0);
    i_en = 1'b1;
    tick();
    send(4'b0001);
    for (int i = 0; i < 4; i++) tick();
    check_all("a.wend", ST_WAIT_END, 4'b0010, 1, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check_all("a.rst_mid_wend", ST_IDLE, 4'b0000, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_all("a.rewstart", ST_WAIT_START, 4'b0000, 0, 0, 0, 0);
    send(4'b0001);
    for (int i = 0; i < 4; i++) tick();
    send(4'b0011);
    check_all("a.redone", ST_DONE, 4'b0100, 1, 0, 1, 0);
    i_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
